decripto: RTL and testbench

Streaming 10-bit decryptor that inverts the team's `cripto` cipher. It recovers plaintext from ciphertext under a shared 10-bit key. The key-derived mask is computed sequentially by a small schedule FSM built on the shared `perm10` and `rotatel2` modules. The datapath sits behind a valid/ready handshake with a small output FIFO, so it can be placed on a stream between a transport and a consumer.

---
 rtl/decripto.sv | 197 +++++++++++++++++++
 tb/tb_decripto.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decripto.sv
// decripto: streaming 10-bit decryptor that inverts cripto. A sequential key
// schedule built around one shared perm10 derives the mask fkey. Each input
// word is XORed with fkey when it is accepted. The result is stored in a
// small output FIFO that sits behind valid/ready handshakes.

// Fixed 10-bit bit permutation shared with cripto.
module perm10 (
  input  logic [9:0] din,
  output logic [9:0] dout
);
  assign dout = {din[7], din[5], din[8], din[3], din[6],
                 din[0], din[9], din[1], din[2], din[4]};
endmodule

// Rotate a 10-bit word left by two positions.
module rotatel2 (
  input  logic [9:0] din,
  output logic [9:0] dout
);
  assign dout = {din[7:0], din[9:8]};
endmodule

module decripto #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] key,
  input  logic       key_load,
  output logic       key_valid,
  input  logic [9:0] ciphertext,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] plaintext,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_K0    = 3'd1,
    S_K1    = 3'd2,
    S_K2    = 3'd3,
    S_K3    = 3'd4,
    S_FK    = 3'd5,
    S_READY = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] key_q, key_d;
  logic [9:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic [9:0] fkey_q, fkey_d;
  logic [9:0] perm_in_s, perm_out_s;
  logic [9:0] rot_k0_s, rot_k1_s, rot_k2_s, rot_k3_s, rot_key_s;

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s, pop_s;

  perm10   u_perm  (.din(perm_in_s), .dout(perm_out_s));
  rotatel2 u_rot_k0  (.din(k0_q),  .dout(rot_k0_s));
  rotatel2 u_rot_k1  (.din(k1_q),  .dout(rot_k1_s));
  rotatel2 u_rot_k2  (.din(k2_q),  .dout(rot_k2_s));
  rotatel2 u_rot_k3  (.din(k3_q),  .dout(rot_k3_s));
  rotatel2 u_rot_key (.din(key_q), .dout(rot_key_s));

  // Key schedule next state: one perm10 step per state; key_load restarts from K0.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    k0_d      = k0_q;
    k1_d      = k1_q;
    k2_d      = k2_q;
    k3_d      = k3_q;
    fkey_d    = fkey_q;
    perm_in_s = 10'h000;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_K0: begin
        perm_in_s = key_q;
        k0_d      = perm_out_s;
        state_d   = S_K1;
      end
      S_K1: begin
        perm_in_s = key_q ^ k0_q;
        k1_d      = perm_out_s;
        state_d   = S_K2;
      end
      S_K2: begin
        perm_in_s = ~k1_q & key_q;
        k2_d      = perm_out_s;
        state_d   = S_K3;
      end
      S_K3: begin
        perm_in_s = k2_q ^ (k0_q & ~key_q);
        k3_d      = perm_out_s;
        state_d   = S_FK;
      end
      S_FK: begin
        fkey_d  = k0_q ^ k1_q ^ k2_q ^ k3_q ^ ~rot_k0_s ^ ~rot_k1_s
                  ^ ~rot_k2_s ^ ~rot_k3_s ^ ~rot_key_s;
        state_d = S_READY;
      end
      S_READY: state_d = S_READY;
      default: state_d = S_IDLE;
    endcase
    if (key_load) begin
      key_d   = key;
      state_d = S_K0;
    end else begin
      key_d   = key_q;
    end
  end

  // Key schedule registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      key_q   <= 10'h000;
      k0_q    <= 10'h000;
      k1_q    <= 10'h000;
      k2_q    <= 10'h000;
      k3_q    <= 10'h000;
      fkey_q  <= 10'h000;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      k3_q    <= k3_d;
      fkey_q  <= fkey_d;
    end
  end

  // Handshake status derived only from registered state, never from in_valid/out_ready.
  always_comb begin
    key_valid = (state_q == S_READY);
    in_ready  = key_valid && (count_q < CW'(FIFO_DEPTH));
    out_valid = (count_q != {CW{1'b0}});
    if (out_valid) begin
      plaintext = mem_q[rd_ptr_q];
    end else begin
      plaintext = 10'h000;
    end
  end

  // FIFO pointer and occupancy update; pointers wrap naturally as depth is a power of two.
  always_comb begin
    push_s   = in_valid && in_ready;
    pop_s    = out_valid && out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // FIFO storage: words are decrypted with the current mask at enqueue time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 10'h000;
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= ciphertext ^ fkey_q;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_decripto.sv
// Self-checking bench for decripto. A behavioural reference model (queue-based
// FIFO, countdown key schedule, cipher as XOR with the key mask) is compared
// with the DUT on every falling edge. A few literal expectations pin timing
// and the key-0 mask.
module tb_decripto;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] key = 10'h000;
  logic       key_load = 1'b0;
  logic       key_valid;
  logic [9:0] ciphertext = 10'h000;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] plaintext;
  logic       out_valid;
  logic       out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  decripto #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .key(key), .key_load(key_load),
    .key_valid(key_valid), .ciphertext(ciphertext), .in_valid(in_valid),
    .in_ready(in_ready), .plaintext(plaintext), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] p10(input logic [9:0] x);
    int src [10];
    logic [9:0] r;
    src = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    r = 10'h000;
    for (int i = 0; i < 10; i++) r[9-i] = x[10-src[i]];
    return r;
  endfunction

  function automatic logic [9:0] rl2(input logic [9:0] x);
    logic [9:0] r;
    r = (x << 2) | (x >> 8);
    return r;
  endfunction

  function automatic logic [9:0] fkey_of(input logic [9:0] k);
    logic [9:0] a, b, c, d;
    a = p10(k);
    b = p10(k ^ a);
    c = p10(~b & k);
    d = p10(c ^ (a & ~k));
    return a ^ b ^ c ^ d ^ ~rl2(a) ^ ~rl2(b) ^ ~rl2(c) ^ ~rl2(d) ^ ~rl2(k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic       m_kv = 1'b0;
  int         m_cnt = 0;
  logic [9:0] m_fkey = 10'h000;
  logic [9:0] m_pend = 10'h000;
  logic [9:0] mq [$];
  logic [9:0] oq [$];
  logic [9:0] cur_word = 10'h000;
  logic [9:0] cur_key = 10'h000;

  // Model update at each active edge; cleared asynchronously by reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_kv = 1'b0; m_cnt = 0; m_fkey = 10'h000; m_pend = 10'h000;
      mq.delete(); oq.delete();
    end else begin : upd
      bit push, pop;
      push = in_valid && m_kv && (mq.size() < D);
      pop  = out_ready && (mq.size() > 0);
      if (pop) begin
        void'(mq.pop_front());
        void'(oq.pop_front());
      end
      if (push) begin
        mq.push_back(ciphertext ^ m_fkey);
        oq.push_back(cur_word);
      end
      if (key_load) begin
        m_kv = 1'b0; m_cnt = 5; m_pend = fkey_of(key);
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_kv = 1'b1; m_fkey = m_pend; end
      end
    end
  end

  // Compare DUT outputs with the model on every falling edge.
  always @(negedge clk) begin : cmp
    logic [9:0] e;
    if (!reset) begin
      chk("rst_key_valid", key_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_plaintext", plaintext, 0);
    end else begin
      e = (mq.size() > 0) ? mq[0] : 10'h000;
      chk("key_valid", key_valid, m_kv);
      chk("in_ready", in_ready, m_kv && (mq.size() < D));
      chk("out_valid", out_valid, mq.size() > 0);
      chk("plaintext", plaintext, e);
      if (mq.size() > 0 && out_ready) chk("roundtrip", plaintext, oq[0]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_key(input logic [9:0] k);
    key = k; cur_key = k; key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!key_valid && n < 30) begin tick(); n++; end
    if (!key_valid) begin
      checks++; errors++;
      $display("FAIL wait_ready actual=timeout required=key_valid");
    end
  endtask

  task automatic set_word(input logic [9:0] w);
    cur_word = w;
    ciphertext = w ^ fkey_of(cur_key);
  endtask

  initial begin
    int n, acc;
    logic [9:0] held;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Key 0: latency and literal decrypt
    key = 10'h000; cur_key = 10'h000; key_load = 1'b1; n = 0;
    do begin tick(); n++; key_load = 1'b0; end while (!key_valid && n < 20);
    chk("kv_latency_key0", n, 6);
    out_ready = 1'b1; cur_word = 10'h2AA; ciphertext = 10'h155; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lit_out_valid", out_valid, 1);
    chk("lit_plain_2aa", plaintext, 10'h2AA);
    tick();

    // Backpressure
    load_key(10'h2C7); wait_ready();
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_word(10'($urandom));
      @(negedge clk); if (in_ready) acc++;
      tick();
    end
    chk("bp_accepted", acc, D);
    chk("bp_in_ready_low", in_ready, 0);
    held = plaintext;
    repeat (3) tick();
    chk("bp_plain_held", plaintext, held);
    out_ready = 1'b1; acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_word(10'($urandom));
      @(negedge clk); if (in_ready) acc++;
      tick();
    end
    chk("bp_resume", acc, 5);
    in_valid = 1'b0;
    repeat (3) tick();

    // Rekey with data queued
    load_key(10'h0F3); wait_ready();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin set_word(10'($urandom)); tick(); end
    in_valid = 1'b0;
    load_key(10'h31A);
    out_ready = 1'b1;
    wait_ready();
    in_valid = 1'b1; set_word(10'h1E5);
    tick();
    in_valid = 1'b0;
    chk("rekey_new_word", plaintext, 10'h1E5);
    tick();

    // Restart mid-schedule
    key = 10'h0AB; cur_key = 10'h0AB; key_load = 1'b1; n = 0;
    do begin
      tick(); n++;
      key_load = (n == 3);
      if (n == 3) begin key = 10'h354; cur_key = 10'h354; end
    end while (!key_valid && n < 30);
    chk("kv_latency_restart", n, 9);
    in_valid = 1'b1; set_word(10'h0C3);
    tick();
    in_valid = 1'b0;
    chk("restart_word", plaintext, 10'h0C3);
    tick();

    // Randomized round trip: 8 keys x 8 words
    for (int r = 0; r < 8; r++) begin
      int sent, guard;
      in_valid = 1'b0;
      load_key(10'($urandom));
      wait_ready();
      sent = 0; guard = 0;
      while (sent < 8 && guard < 200) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = ($urandom_range(0, 3) != 0);
        set_word(10'($urandom));
        @(negedge clk); if (in_valid && in_ready) sent++;
        tick(); guard++;
      end
      chk("rand_sent", sent, 8);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    // Async reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; set_word(10'h123);
    repeat (2) tick();
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("ar_key_valid", key_valid, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_plaintext", plaintext, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("ar_no_out", out_valid, 0);
    chk("ar_no_key", key_valid, 0);
    in_valid = 1'b0;
    load_key(10'h2E1); wait_ready();
    in_valid = 1'b1; set_word(10'h39C);
    tick();
    in_valid = 1'b0;
    chk("ar_recover", plaintext, 10'h39C);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
